// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the ALU arbiter.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_NAND = 4'd7;
   localparam logic [3:0] ALU_NOR  = 4'd12;
   localparam logic [3:0] ALU_XOR  = 4'd13;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant logic; ALU_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module alu_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       owner
);

   // last granted requester; doubles as the pending-result owner
   logic last;

   always_comb begin
      grant = req;
      unique case (1'b1)
         (req == 2'b11): begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant = last ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
         end
         default: grant = req;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
      end else if (accept) begin
         last <= grant[1];
      end
   end

   assign owner = last;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester shared ALU with one registered result slot.
// Build option: ALU_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [7:0]         req_ctl,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_out,
   output logic               rsp_zero
);

   state_t           state;
   logic [1:0]       grant;
   logic             owner;
   logic             win;
   logic             free;
   logic             accept;
   logic [3:0]       win_ctl;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [WIDTH-1:0] alu_res;

   function automatic logic [WIDTH-1:0] alu_calc(
      input logic [3:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      unique case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_NOR:  r = ~(a | b);
         ALU_NAND: r = ~(a & b);
         ALU_XOR:  r = a ^ b;
         default:  r = '0;
      endcase
      return r;
   endfunction

   alu_rr_arbiter u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .accept (accept),
      .grant  (grant),
      .owner  (owner)
   );

   always_comb begin
      win     = grant[1];
      win_ctl = win ? req_ctl[7:4] : req_ctl[3:0];
      win_a   = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      win_b   = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      alu_res = alu_calc(win_ctl, win_a, win_b);
   end

   // the slot is free when empty or being drained this cycle
   always_comb begin
      free      = (state == ST_IDLE) || rsp_ready[owner];
      req_ready = (!rst && free) ? grant : 2'b00;
      accept    = |req_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         rsp_valid <= 2'b00;
         rsp_out   <= '0;
         rsp_zero  <= 1'b1;
      end else if (accept) begin
         state     <= ST_HOLD;
         rsp_valid <= onehot2(win);
         rsp_out   <= alu_res;
         rsp_zero  <= (alu_res == '0);
      end else if (state == ST_HOLD && rsp_ready[owner]) begin
         state     <= ST_IDLE;
         rsp_valid <= 2'b00;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: op table plus arbitration, stall and reset sequences.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_ctl;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_out;
   logic        rsp_zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        who;
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] out;
      logic        zero;
   } vec_t;

   vec_t tv[11];

   alu_arbiter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctl   (req_ctl),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_out   (rsp_out),
      .rsp_zero  (rsp_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic who, input logic [3:0] ctl,
                        input logic [31:0] a, input logic [31:0] b);
      if (who) begin
         req_ctl = {ctl, 4'd2};
         req_a   = {a, 32'hDEAD_0000};
         req_b   = {b, 32'h0000_BEEF};
      end else begin
         req_ctl = {4'd2, ctl};
         req_a   = {32'hDEAD_0000, a};
         req_b   = {32'h0000_BEEF, b};
      end
      req_valid = who ? 2'b10 : 2'b01;
   endtask

   task automatic pulse_rst;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] g;

      tv[0]  = '{1'b0, ALU_ADD,  32'd5,         32'd7,         32'd12,        1'b0};
      tv[1]  = '{1'b1, ALU_SUB,  32'h1234,      32'h1234,      32'h0,         1'b1};
      tv[2]  = '{1'b1, ALU_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0};
      tv[3]  = '{1'b0, ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0};
      tv[4]  = '{1'b1, ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
      tv[5]  = '{1'b0, ALU_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
      tv[6]  = '{1'b1, ALU_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1};
      tv[7]  = '{1'b0, ALU_XOR,  32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0};
      tv[8]  = '{1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0};
      tv[9]  = '{1'b0, 4'd9,     32'h55,        32'h66,        32'h0,         1'b1};
      tv[10] = '{1'b1, 4'd15,    32'h77,        32'h88,        32'h0,         1'b1};

      rst       = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      req_ctl   = 8'h22;
      req_a     = 64'h1;
      req_b     = 64'h1;
      #2;
      chk("rst_valid", rsp_valid, 2'b00);
      chk("rst_out",   rsp_out,   32'h0);
      chk("rst_zero",  rsp_zero,  1'b1);
      chk("rst_ready", req_ready, 2'b00);
      tick;
      chk("rst_ready_edge", req_ready, 2'b00);
      chk("rst_valid_edge", rsp_valid, 2'b00);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 2'b00;
      tick;

      // op table, back-to-back with consumer always ready
      rsp_ready = 2'b11;
      for (int i = 0; i < 11; i++) begin
         drive(tv[i].who, tv[i].ctl, tv[i].a, tv[i].b);
         #1;
         chk($sformatf("v%0d_ready", i), req_ready, onehot2(tv[i].who));
         tick;
         chk($sformatf("v%0d_valid", i), rsp_valid, onehot2(tv[i].who));
         chk($sformatf("v%0d_out", i),   rsp_out,   tv[i].out);
         chk($sformatf("v%0d_zero", i),  rsp_zero,  tv[i].zero);
      end
      req_valid = 2'b00;
      tick;
      chk("drain_idle", rsp_valid, 2'b00);

      // simultaneous requests for 4 cycles
      pulse_rst;
      req_valid = 2'b11;
      req_ctl   = {ALU_ADD, ALU_ADD};
      req_a     = {32'd2, 32'd1};
      req_b     = 64'h0;
      rsp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         g = k[0] ? 2'b10 : 2'b01;
`else
         g = 2'b01;
`endif
         #1;
         chk($sformatf("arb%0d_ready", k), req_ready, g);
         tick;
         chk($sformatf("arb%0d_valid", k), rsp_valid, g);
         chk($sformatf("arb%0d_out", k), rsp_out, (g == 2'b01) ? 32'd1 : 32'd2);
      end

      // owner stalls; non-owner ready must be ignored
      pulse_rst;
      rsp_ready = 2'b00;
      drive(1'b0, ALU_ADD, 32'd5, 32'd7);
      #1;
      chk("stall_acc_ready", req_ready, 2'b01);
      tick;
      chk("stall_out0", rsp_out, 32'd12);
      req_valid      = 2'b11;
      req_a[31:0]    = 32'd100;
      rsp_ready      = 2'b10;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d_ready", k), req_ready, 2'b00);
         chk($sformatf("stall%0d_out", k),   rsp_out,   32'd12);
         chk($sformatf("stall%0d_valid", k), rsp_valid, 2'b01);
         tick;
      end
      chk("stall_out_end", rsp_out, 32'd12);
      rsp_ready = 2'b01;
      drive(1'b1, ALU_OR, 32'd3, 32'd4);
      #1;
      chk("release_ready", req_ready, 2'b10);
      tick;
      chk("release_valid", rsp_valid, 2'b10);
      chk("release_out",   rsp_out,   32'd7);
      chk("release_zero",  rsp_zero,  1'b0);
      req_valid = 2'b00;
      rsp_ready = 2'b10;
      tick;
      chk("release_idle", rsp_valid, 2'b00);

      // reset while a result is pending
      rsp_ready = 2'b00;
      drive(1'b0, ALU_ADD, 32'd1, 32'd1);
      tick;
      chk("mid_hold_out",   rsp_out,   32'd2);
      chk("mid_hold_valid", rsp_valid, 2'b01);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", rsp_valid, 2'b00);
      chk("mid_rst_out",   rsp_out,   32'h0);
      chk("mid_rst_zero",  rsp_zero,  1'b1);
      chk("mid_rst_ready", req_ready, 2'b00);
      #1;
      rst = 1'b0;
      rsp_ready = 2'b11;
      drive(1'b0, ALU_ADD, 32'd5, 32'd5);
      tick;
      chk("post_rst_add", rsp_out, 32'd10);
      drive(1'b1, 4'd9, 32'd5, 32'd5);
      #1;
      chk("bad_op_ready", req_ready, 2'b10);
      tick;
      chk("bad_op_out",   rsp_out,   32'h0);
      chk("bad_op_zero",  rsp_zero,  1'b1);
      chk("bad_op_valid", rsp_valid, 2'b10);
      req_valid = 2'b00;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 SHALL have port: req_ready  output  2  per-requester accept, at most one bit set.
REQ-006 SHALL have port: req_ctl  input  8  op code, bits [4i+3:4i] for requester i.
REQ-007 SHALL have port: req_a  input  2*WIDTH  operand A, slice i for requester i.
REQ-008 SHALL have port: req_b  input  2*WIDTH  operand B, slice i for requester i.
REQ-009 SHALL have port: rsp_valid  output  2  result valid for requester i, one-hot or zero.
REQ-010 SHALL have port: rsp_ready  input  2  requester i consumes result.
REQ-011 SHALL have port: rsp_out  output  WIDTH  registered result, shared by both requesters.
REQ-012 SHALL have port: rsp_zero  output  1  registered flag, 1 when rsp_out == 0.

Function
REQ-013 SHALL compute by ctl: 2 add, 6 sub, 0 and, 1 or, 12 nor, 7 nand, 13 xor; any other code yields 0.
REQ-014 SHALL truncate add/sub modulo 2^WIDTH; no carry/overflow output.
REQ-015 SHALL implement FSM IDLE/HOLD; HOLD owner = requester whose result is pending.
REQ-016 SHALL in IDLE, with any req_valid set, assert req_ready for the arbitration winner, capture its result on that edge, enter HOLD.
REQ-017 SHALL in HOLD assert rsp_valid[owner] only; rsp_out/rsp_zero held stable until rsp_ready[owner].
REQ-018 SHALL in HOLD with rsp_ready[owner]=1 and any req_valid, accept the winner in the same cycle (back-to-back, stay HOLD); with no req_valid, go IDLE.
REQ-019 SHALL derive req_ready combinationally from state, req_valid, rsp_ready[owner]; never set in HOLD without rsp_ready[owner].
REQ-020 SHALL have latency 1: accept on edge N, rsp_valid visible after edge N; throughput 1 op/cycle when rsp_ready held high.
REQ-021 SHALL ignore rsp_ready of the non-owner and allow req_valid drop before acceptance with no state effect.

Reset
REQ-022 SHALL on rst: state IDLE, rsp_valid=0, rsp_out=0, rsp_zero=1, arbitration pointer favours requester 0; pending result discarded.
REQ-023 SHALL hold req_ready=0 while rst is high.

Configuration
REQ-024 SHALL with ALU_ARB_ROUND_ROBIN_EN defined, on simultaneous requests grant the requester not granted last; pointer updates only on acceptance.
REQ-025 SHALL without ALU_ARB_ROUND_ROBIN_EN, grant requester 0 on every conflict (fixed priority).

Structure
REQ-026 SHALL take op-code constants (ALU_ADD=2, ALU_SUB=6, ALU_AND=0, ALU_OR=1, ALU_NOR=12, ALU_NAND=7, ALU_XOR=13) and FSM state encoding from shared package alu_pkg.
REQ-027 SHALL place the 2-way grant logic (fixed/round-robin, pointer register) in sub-module alu_rr_arbiter.

Verification
REQ-028 SHALL cover: req_valid=01, ctl=2, a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=01, rsp_out=12, rsp_zero=0.
REQ-029 SHALL cover: req 1 ctl=6, a=b=0x1234 -> rsp_valid=10, rsp_out=0, rsp_zero=1; ctl=6, a=0, b=1 -> rsp_out=0xFFFFFFFF.
REQ-030 SHALL cover: req_valid=11 held 4 cycles, rsp_ready=11 -> grants 0,1,0,1 with macro; 0,0,0,0 without.
REQ-031 SHALL cover: rsp_ready[owner]=0 for 3 cycles -> rsp_out stable, req_ready=00; then rsp_ready=1 with req_valid -> new accept same cycle.
REQ-032 SHALL cover: rst asserted mid-HOLD -> rsp_valid=00, rsp_out=0, rsp_zero=1 immediately; ctl=9 request after reset -> rsp_out=0.
